// File: rtl/autoconfig_seq.sv
// Power-up configuration sequencer: walks a writable {addr,data} table and issues
// every entry to each ADC channel over the config_start/config_done handshake.
module autoconfig_seq #(
  parameter int NUM_CHANNELS = 2,
  parameter int REG_COUNT    = 9,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int TIMEOUT      = 1023,
  parameter int MAX_RETRIES  = 2,
  parameter int AUTO_START   = 1,
  parameter logic [REG_COUNT*(ADDR_WIDTH+DATA_WIDTH)-1:0] DEFAULT_TABLE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_chan,
  output logic [3:0]            err_index,
  output logic [DATA_WIDTH-1:0] config_data,
  output logic [ADDR_WIDTH-1:0] config_addr,
  output logic [2:0]            config_chan,
  output logic                  config_start,
  input  logic                  config_done,
  input  logic                  tbl_we,
  input  logic [3:0]            tbl_index,
  input  logic [ADDR_WIDTH-1:0] tbl_waddr,
  input  logic [DATA_WIDTH-1:0] tbl_wdata
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int TN = 2 ** IW;
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  // Table is padded to a power of two so the index never runs past the array.
  localparam logic [TN*EW-1:0] DEF_PAD = (TN*EW)'(DEFAULT_TABLE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            r_state;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_chan;
  logic [RW-1:0]         r_retries;
  logic [TW-1:0]         r_timer;
  logic                  r_auto_pend;
  logic                  r_cfg_start;
  logic                  r_error;
  logic [CW-1:0]         r_err_chan;
  logic [IW-1:0]         r_err_index;
  logic [ADDR_WIDTH-1:0] r_cfg_addr;
  logic [DATA_WIDTH-1:0] r_cfg_data;
  logic [CW-1:0]         r_cfg_chan;
  logic [EW-1:0]         r_tbl [TN];
  logic                  w_busy;
  logic                  w_tbl_wr;

  assign w_busy   = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_NEXT);
  assign w_tbl_wr = tbl_we && !w_busy && ({28'b0, tbl_index} < 32'(REG_COUNT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_chan      <= '0;
      r_retries   <= '0;
      r_timer     <= '0;
      r_auto_pend <= (AUTO_START != 0);
      r_cfg_start <= 1'b0;
      r_error     <= 1'b0;
      r_err_chan  <= '0;
      r_err_index <= '0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_cfg_chan  <= '0;
      for (int unsigned i = 0; i < TN; i++) r_tbl[i] <= DEF_PAD[i*EW +: EW];
    end else begin
      r_cfg_start <= 1'b0;
      r_auto_pend <= 1'b0;
      if (w_tbl_wr) r_tbl[tbl_index[IW-1:0]] <= {tbl_waddr, tbl_wdata};
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start || r_auto_pend) begin
            r_error     <= 1'b0;
            r_err_chan  <= '0;
            r_err_index <= '0;
            r_idx       <= '0;
            r_chan      <= '0;
            r_retries   <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          {r_cfg_addr, r_cfg_data} <= r_tbl[r_idx];
          r_cfg_chan  <= r_chan;
          r_cfg_start <= 1'b1;
          r_timer     <= TW'(TIMEOUT);
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (config_done) begin
            r_state <= S_NEXT;
          end else if (r_timer == '0) begin
            if (r_retries < RW'(MAX_RETRIES)) begin
              r_retries <= r_retries + RW'(1);
              r_state   <= S_ISSUE;
            end else begin
              // Only the first failure of a run is recorded.
              if (!r_error) begin
                r_error     <= 1'b1;
                r_err_chan  <= r_chan;
                r_err_index <= r_idx;
              end
              r_state <= S_NEXT;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_NEXT: begin
          r_retries <= '0;
          if (r_idx == IW'(REG_COUNT - 1)) begin
            r_idx <= '0;
            if (r_chan == CW'(NUM_CHANNELS - 1)) begin
              r_state <= S_DONE;
            end else begin
              r_chan  <= r_chan + CW'(1);
              r_state <= S_ISSUE;
            end
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = w_busy;
  assign done         = (r_state == S_DONE);
  assign error        = r_error;
  assign err_chan     = 3'(r_err_chan);
  assign err_index    = 4'(r_err_index);
  assign config_data  = r_cfg_data;
  assign config_addr  = r_cfg_addr;
  assign config_chan  = 3'(r_cfg_chan);
  assign config_start = r_cfg_start;

endmodule

// File: tb/tb_autoconfig_seq.sv
// Directed bench for autoconfig_seq: a behavioural serial engine answers each
// config_start according to a per-run plan; issues are logged and checked.
module tb_autoconfig_seq;

  localparam logic [59:0] DEF = {4'h3, 16'hC003, 4'h2, 16'hB002, 4'h1, 16'hA001};

  logic        clk = 1'b0;
  logic        rst, start, config_done, tbl_we;
  logic [3:0]  tbl_index, tbl_waddr;
  logic [15:0] tbl_wdata;
  logic        busy, done, error, config_start;
  logic [2:0]  err_chan, config_chan;
  logic [3:0]  err_index, config_addr;
  logic [15:0] config_data;

  autoconfig_seq #(
    .NUM_CHANNELS(2), .REG_COUNT(3), .DATA_WIDTH(16), .ADDR_WIDTH(4),
    .TIMEOUT(8), .MAX_RETRIES(2), .AUTO_START(1), .DEFAULT_TABLE(DEF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .err_chan(err_chan), .err_index(err_index), .config_data(config_data),
    .config_addr(config_addr), .config_chan(config_chan), .config_start(config_start),
    .config_done(config_done), .tbl_we(tbl_we), .tbl_index(tbl_index),
    .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int chan; int addr; int data; int cyc;} rec_t;
  rec_t log_q[$];
  int   mode;
  int   cd_cnt;
  int   attempts [2][3];
  int   checks = 0;
  int   failures = 0;
  int   ec, ei, el;

  function automatic int idx_of(input int a);
    case (a)
      1:       return 0;
      2, 9:    return 1;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int data_of(input int a);
    case (a)
      1:       return 32'hA001;
      2:       return 32'hB002;
      3:       return 32'hC003;
      9:       return 32'h23FF;
      default: return 0;
    endcase
  endfunction

  // Engine latency for (chan, idx, attempt); -1 means never answer.
  function automatic int plan(input int m, input int c, input int i, input int a);
    if (m == 1) begin
      if (c == 0 && i == 1) return (a == 0) ? -1 : 5;
      if (c == 0 && i == 2) return (a < 2) ? -1 : 5;
      if (c == 1 && i == 0) return 8;
      if (c == 1 && i == 2) return -1;
    end else if (m == 2) begin
      if (c == 0 && i == 0) return -1;
    end
    return 5;
  endfunction

  initial begin
    config_done = 1'b0;
    cd_cnt = 0;
    forever begin
      @(negedge clk);
      config_done = 1'b0;
      if (!rst) cd_cnt = 0;
      else if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) config_done = 1'b1;
      end
      if (config_start === 1'b1) begin
        ec = int'(config_chan);
        ei = idx_of(int'(config_addr));
        log_q.push_back('{ec, int'(config_addr), int'(config_data), cyc});
        el = 5;
        if (ec < 2) begin
          el = plan(mode, ec, ei, attempts[ec][ei]);
          attempts[ec][ei]++;
        end
        cd_cnt = (el < 0) ? 0 : el;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_entry(input string tag, input int k, input int c, input int a);
    logic [31:0] obs, exp;
    exp = c * 32'h100000 + a * 32'h10000 + data_of(a);
    if (k < log_q.size()) obs = log_q[k].chan * 32'h100000 + log_q[k].addr * 32'h10000 + log_q[k].data;
    else obs = 32'hFFFFFFFF;
    chk($sformatf("%s[%0d]", tag, k), obs, exp);
  endtask

  function automatic int gap(input int a, input int b);
    if (b < log_q.size()) return log_q[b].cyc - log_q[a].cyc;
    return -1;
  endfunction

  task automatic clear_log();
    log_q.delete();
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++) attempts[a][b] = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic tbl_write(input logic [3:0] i, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_index = i; tbl_waddr = a; tbl_wdata = d;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (done !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int cnt, input int maxc);
    int n = 0;
    while (log_q.size() < cnt && n < maxc) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(log_q.size() >= cnt), 32'd1);
  endtask

  int run1_addr [6] = '{1, 2, 3, 1, 2, 3};
  int run2_addr [6] = '{1, 9, 3, 1, 9, 3};
  int run3_chan [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int run3_addr [11] = '{1, 9, 9, 3, 3, 3, 1, 9, 3, 3, 3};
  int held;

  initial begin
    rst = 1'b0; start = 1'b0; tbl_we = 1'b0;
    tbl_index = '0; tbl_waddr = '0; tbl_wdata = '0;
    mode = 0;
    clear_log();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cfg_start", 32'(config_start), 0);
    chk("rst_err_index", 32'(err_index), 0);

    // Run 1: auto-start from reset, default table, clean engine.
    rst = 1'b1;
    wait_done("run1_done", 400);
    chk("run1_starts", log_q.size(), 6);
    for (int k = 0; k < 6; k++) chk_entry("run1_seq", k, k / 3, run1_addr[k]);
    chk("run1_gap", gap(0, 1), 8);
    chk("run1_busy", 32'(busy), 0);
    chk("run1_error", 32'(error), 0);
    chk("run1_hold", {13'b0, config_chan, config_addr, config_data}, {13'b0, 3'd1, 4'h3, 16'hC003});

    // Run 2: table rewrite while idle, ignored out-of-range and mid-run writes.
    tbl_write(4'd1, 4'h9, 16'h23FF);
    tbl_write(4'd5, 4'hE, 16'hDEAD);
    clear_log();
    pulse_start();
    chk("run2_done_clr", 32'(done), 0);
    chk("run2_busy", 32'(busy), 1);
    wait_starts("run2_first", 1, 100);
    tbl_write(4'd0, 4'hF, 16'hBEEF);
    pulse_start();
    wait_done("run2_done", 400);
    chk("run2_starts", log_q.size(), 6);
    for (int k = 0; k < 6; k++) chk_entry("run2_seq", k, k / 3, run2_addr[k]);
    chk("run2_error", 32'(error), 0);

    // Run 3: retry on (0,1), retries reset so (0,2) wins on 3rd try,
    // done on the timeout cycle for (1,0), (1,2) never answers.
    mode = 1;
    clear_log();
    pulse_start();
    wait_done("run3_done", 600);
    chk("run3_starts", log_q.size(), 11);
    for (int k = 0; k < 11; k++) chk_entry("run3_seq", k, run3_chan[k], run3_addr[k]);
    chk("run3_gap_ok", gap(0, 1), 8);
    chk("run3_gap_retry01", gap(1, 2), 10);
    chk("run3_gap_ok01", gap(2, 3), 8);
    chk("run3_gap_retry02a", gap(3, 4), 10);
    chk("run3_gap_retry02b", gap(4, 5), 10);
    chk("run3_gap_exact_to", gap(6, 7), 11);
    chk("run3_gap_fail12a", gap(8, 9), 10);
    chk("run3_gap_fail12b", gap(9, 10), 10);
    chk("run3_error", 32'(error), 1);
    chk("run3_err_chan", 32'(err_chan), 1);
    chk("run3_err_index", 32'(err_index), 2);

    // Run 4: (0,0) fails, then reset lands in WAIT of (1,0).
    mode = 2;
    clear_log();
    pulse_start();
    chk("run4_err_clr", 32'(error), 0);
    wait_starts("run4_reach10", 6, 300);
    chk_entry("run4_seq", 5, 1, 1);
    chk("run4_pre_busy", 32'(busy), 1);
    chk("run4_pre_cfg_start", 32'(config_start), 1);
    chk("run4_pre_error", 32'(error), 1);
    rst = 1'b0;
    #1;
    chk("run4_rst_busy", 32'(busy), 0);
    chk("run4_rst_cfg_start", 32'(config_start), 0);
    chk("run4_rst_error", 32'(error), 0);
    held = log_q.size();
    repeat (4) @(negedge clk);
    chk("run4_no_issue_in_rst", log_q.size(), held);

    // Run 5: release restarts at (0,0) with the default table restored.
    mode = 0;
    clear_log();
    rst = 1'b1;
    wait_done("run5_done", 400);
    chk("run5_starts", log_q.size(), 6);
    for (int k = 0; k < 6; k++) chk_entry("run5_seq", k, k / 3, run1_addr[k]);
    chk("run5_error", 32'(error), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/autoconfig_seq.md
Name: autoconfig_seq

Overview:
- Parametrised power-up configuration sequencer for multi-ADC controllers.
- Walks a run-time writable register table (address/data pairs) and issues each entry to every ADC channel over the existing serial-config handshake (config_start/config_done).
- Adds per-write timeout with bounded retry, error capture, and software re-trigger.
- Sits between the OPB register file and the serial config engine.

Parameters:
NUM_CHANNELS, 2, ADC channels configured in sequence; range 1..8.
REG_COUNT, 9, table entries per channel; range 1..16.
DATA_WIDTH, 16, config word width.
ADDR_WIDTH, 4, config register address width.
TIMEOUT, 1023, cycles to wait for config_done before a retry; must be ≥1.
MAX_RETRIES, 2, re-issues after the first attempt before an entry is declared failed.
AUTO_START, 1, 1 = sequence starts on reset release; 0 = waits for start.
DEFAULT_TABLE, 0, flattened REG_COUNT*(ADDR_WIDTH+DATA_WIDTH) vector; entry i = bits [i*(A+D) +: A+D] = {addr, data}.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
busy  out  1  high while a run is in progress.
done  out  1  high in DONE until the next start.
error  out  1  sticky; at least one entry failed in the current/last run.
err_chan  out  3  channel of the first failure.
err_index  out  4  table index of the first failure.
config_data  out  DATA_WIDTH  data of the current entry.
config_addr  out  ADDR_WIDTH  address of the current entry.
config_chan  out  3  target channel of the current entry.
config_start  out  1  one-cycle request to the serial engine.
config_done  in  1  one-cycle completion from the serial engine.
tbl_we  in  1  table write strobe.
tbl_index  in  4  table entry written.
tbl_waddr  in  ADDR_WIDTH  address field written.
tbl_wdata  in  DATA_WIDTH  data field written.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM→IDLE; idx, chan, retries, timer = 0; config_start = 0; done = 0; error = 0; err_chan/err_index = 0.
  - Table reloads from DEFAULT_TABLE.
  - On release: AUTO_START=1 enters ISSUE on the first clk edge; otherwise stays IDLE.
  - Reset mid-run aborts with no further config_start.
- States: IDLE, ISSUE, WAIT, NEXT, DONE. busy = (state ∈ {ISSUE, WAIT, NEXT}).
- IDLE/DONE + start: clear error, err_*, done; idx = chan = retries = 0; →ISSUE.
- ISSUE (1 cycle):
  - config_start = 1 on the following cycle (registered); timer = TIMEOUT.
  - config_addr/config_data/config_chan come from table[idx]/chan and are held stable until NEXT.
  - →WAIT.
- WAIT:
  - config_done → NEXT.
  - Else if timer == 0: if retries < MAX_RETRIES, then retries++ and →ISSUE; else on the first failure of the run latch error = 1, err_chan = chan, err_index = idx (later failures keep error high, do not overwrite), then →NEXT (entry skipped).
  - Else timer decrements.
  - config_done arriving in the same cycle as the timeout wins (success).
- NEXT (1 cycle):
  - retries = 0.
  - If idx == REG_COUNT-1: idx = 0; if chan == NUM_CHANNELS-1 →DONE, else chan++ and →ISSUE.
  - Else idx++ and →ISSUE.
- DONE: done = 1, busy = 0; outputs hold the last entry.
- config_done outside WAIT is ignored. start while busy is ignored.
- Table writes:
  - Accepted only when busy = 0; dropped silently while busy.
  - tbl_index ≥ REG_COUNT is ignored.
  - Written entry is visible at the next ISSUE.
- Successful-run latency: NUM_CHANNELS*REG_COUNT*(2 + engine latency + 1) cycles.
- Unused high bits of err_chan, config_chan, err_index read 0.

Test Plan:
- AUTO_START=1, REG_COUNT=3, NUM_CHANNELS=2, engine returns config_done 5 cycles after each start → exactly 6 config_start pulses, order (chan,idx) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); then done=1, busy=0, error=0.
- Write tbl_index=1 with waddr=4'h9, wdata=16'h23FF while idle, then pulse start → second and fifth issues carry addr 9 / data 23FF; a write attempted mid-run is not applied.
- TIMEOUT=8, MAX_RETRIES=2, engine never answers entry (1,2) → 3 starts for that entry, spaced 10 cycles apart; error=1, err_chan=1, err_index=2; sequence still reaches DONE.
- Engine answers entry (0,1) only on its second attempt → 2 starts for that entry, error stays 0, retries reset for the next entry.
- config_done on the exact timeout cycle → no retry, entry counted as success.
- Assert rst low during WAIT on entry (1,0) → busy, config_start, error drop immediately without a clock; table back to DEFAULT_TABLE; on release, AUTO_START=1 restarts at (0,0).
